// File: rtl/dcache_mem_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | dcache_mem_controller: multiplexes per-consumer dcache read/write requests  |
// | onto NUM_CHANNELS memory channels using four-phase valid/ready handshakes.  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module dcache_mem_controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 8,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
  input  logic [ADDR_BITS-1:0]     consumer_read_address  [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
  output logic [DATA_BITS-1:0]     consumer_read_data     [NUM_CONSUMERS],
  input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
  input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS],
  input  logic [DATA_BITS-1:0]     consumer_write_data    [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]  mem_read_valid,
  output logic [ADDR_BITS-1:0]     mem_read_address       [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0]  mem_read_ready,
  input  logic [DATA_BITS-1:0]     mem_read_data          [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0]  mem_write_valid,
  output logic [ADDR_BITS-1:0]     mem_write_address      [NUM_CHANNELS],
  output logic [DATA_BITS-1:0]     mem_write_data         [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0]  mem_write_ready
);

  localparam int c_owner_w  = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam bit c_write_en = (WRITE_ENABLE != 0);

  typedef enum logic [2:0] {
    S_IDLE           = 3'd0,
    S_READ_WAITING   = 3'd1,
    S_WRITE_WAITING  = 3'd2,
    S_READ_RELAYING  = 3'd3,
    S_WRITE_RELAYING = 3'd4
  } state_t;

  state_t               r_state      [NUM_CHANNELS];
  state_t               w_state_nxt  [NUM_CHANNELS];
  logic [c_owner_w-1:0] r_owner      [NUM_CHANNELS];
  logic [c_owner_w-1:0] w_owner_nxt  [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] r_mem_ra     [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] w_mem_ra_nxt [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] r_mem_wa     [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] w_mem_wa_nxt [NUM_CHANNELS];
  logic [DATA_BITS-1:0] r_mem_wd     [NUM_CHANNELS];
  logic [DATA_BITS-1:0] w_mem_wd_nxt [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] r_mem_rv, w_mem_rv_nxt;
  logic [NUM_CHANNELS-1:0] r_mem_wv, w_mem_wv_nxt;

  logic [NUM_CONSUMERS-1:0] r_claimed, w_claimed_nxt, w_busy;
  logic [NUM_CONSUMERS-1:0] r_cons_rr, w_cons_rr_nxt;
  logic [NUM_CONSUMERS-1:0] r_cons_wr, w_cons_wr_nxt;
  logic [DATA_BITS-1:0]     r_cons_rd     [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     w_cons_rd_nxt [NUM_CONSUMERS];
  logic                     w_found;

  // w_busy sees only claims made earlier in this cycle; releases take effect next cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_mem_ra_nxt  = r_mem_ra;
    w_mem_wa_nxt  = r_mem_wa;
    w_mem_wd_nxt  = r_mem_wd;
    w_mem_rv_nxt  = r_mem_rv;
    w_mem_wv_nxt  = r_mem_wv;
    w_claimed_nxt = r_claimed;
    w_busy        = r_claimed;
    w_cons_rr_nxt = r_cons_rr;
    w_cons_wr_nxt = r_cons_wr;
    w_cons_rd_nxt = r_cons_rd;
    w_found       = 1'b0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      case (r_state[ch])
        S_IDLE: begin
          w_found = 1'b0;
          for (int s = 0; s < NUM_CONSUMERS; s++) begin
            if (!w_found && !w_busy[s]) begin
              if (consumer_read_valid[s]) begin
                w_found           = 1'b1;
                w_busy[s]         = 1'b1;
                w_claimed_nxt[s]  = 1'b1;
                w_owner_nxt[ch]   = c_owner_w'(s);
                w_mem_ra_nxt[ch]  = consumer_read_address[s];
                w_mem_rv_nxt[ch]  = 1'b1;
                w_state_nxt[ch]   = S_READ_WAITING;
              end else if (c_write_en && consumer_write_valid[s]) begin
                w_found           = 1'b1;
                w_busy[s]         = 1'b1;
                w_claimed_nxt[s]  = 1'b1;
                w_owner_nxt[ch]   = c_owner_w'(s);
                w_mem_wa_nxt[ch]  = consumer_write_address[s];
                w_mem_wd_nxt[ch]  = consumer_write_data[s];
                w_mem_wv_nxt[ch]  = 1'b1;
                w_state_nxt[ch]   = S_WRITE_WAITING;
              end
            end
          end
        end
        S_READ_WAITING: begin
          if (mem_read_ready[ch]) begin
            w_mem_rv_nxt[ch]              = 1'b0;
            w_cons_rr_nxt[r_owner[ch]]    = 1'b1;
            w_cons_rd_nxt[r_owner[ch]]    = mem_read_data[ch];
            w_state_nxt[ch]               = S_READ_RELAYING;
          end
        end
        S_WRITE_WAITING: begin
          if (mem_write_ready[ch]) begin
            w_mem_wv_nxt[ch]              = 1'b0;
            w_cons_wr_nxt[r_owner[ch]]    = 1'b1;
            w_state_nxt[ch]               = S_WRITE_RELAYING;
          end
        end
        S_READ_RELAYING: begin
          if (!consumer_read_valid[r_owner[ch]]) begin
            w_cons_rr_nxt[r_owner[ch]]    = 1'b0;
            w_cons_rd_nxt[r_owner[ch]]    = '0;
            w_claimed_nxt[r_owner[ch]]    = 1'b0;
            w_state_nxt[ch]               = S_IDLE;
          end
        end
        S_WRITE_RELAYING: begin
          if (!consumer_write_valid[r_owner[ch]]) begin
            w_cons_wr_nxt[r_owner[ch]]    = 1'b0;
            w_claimed_nxt[r_owner[ch]]    = 1'b0;
            w_state_nxt[ch]               = S_IDLE;
          end
        end
        default: w_state_nxt[ch] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        r_state[ch]  <= S_IDLE;
        r_owner[ch]  <= '0;
        r_mem_ra[ch] <= '0;
        r_mem_wa[ch] <= '0;
        r_mem_wd[ch] <= '0;
      end
      for (int s = 0; s < NUM_CONSUMERS; s++) begin
        r_cons_rd[s] <= '0;
      end
      r_mem_rv  <= '0;
      r_mem_wv  <= '0;
      r_claimed <= '0;
      r_cons_rr <= '0;
      r_cons_wr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_mem_ra  <= w_mem_ra_nxt;
      r_mem_wa  <= w_mem_wa_nxt;
      r_mem_wd  <= w_mem_wd_nxt;
      r_cons_rd <= w_cons_rd_nxt;
      r_mem_rv  <= w_mem_rv_nxt;
      r_mem_wv  <= w_mem_wv_nxt;
      r_claimed <= w_claimed_nxt;
      r_cons_rr <= w_cons_rr_nxt;
      r_cons_wr <= w_cons_wr_nxt;
    end
  end

  assign consumer_read_ready  = r_cons_rr;
  assign consumer_read_data   = r_cons_rd;
  assign mem_read_valid       = r_mem_rv;
  assign mem_read_address     = r_mem_ra;
  assign consumer_write_ready = c_write_en ? r_cons_wr : '0;
  assign mem_write_valid      = c_write_en ? r_mem_wv : '0;

  // Without a write path the write-side memory outputs are hard zero.
  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_wr_out
    assign mem_write_address[ch] = c_write_en ? r_mem_wa[ch] : '0;
    assign mem_write_data[ch]    = c_write_en ? r_mem_wd[ch] : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_mem_controller.sv
`default_nettype none
// Bench for dcache_mem_controller: directed scenarios plus randomized traffic
// checked against a memory model where read data = address ^ 8'h54.
`timescale 1ns/1ps
module tb_dcache_mem_controller;
  localparam int AB = 8, DB = 8, NC = 8, NCH_A = 3, NCH_B = 2, TXN = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // DUT A: three channels, write path enabled
  logic [NC-1:0]    a_crv, a_crr, a_cwv, a_cwr;
  logic [AB-1:0]    a_cra [NC];
  logic [AB-1:0]    a_cwa [NC];
  logic [DB-1:0]    a_crd [NC];
  logic [DB-1:0]    a_cwd [NC];
  logic [NCH_A-1:0] a_mrv, a_mwv;
  logic [NCH_A-1:0] a_mrr = '0;
  logic [NCH_A-1:0] a_mwr = '0;
  logic [AB-1:0]    a_mra [NCH_A];
  logic [AB-1:0]    a_mwa [NCH_A];
  logic [DB-1:0]    a_mrd [NCH_A] = '{default: '0};
  logic [DB-1:0]    a_mwd [NCH_A];

  // DUT B: two channels, write path removed
  logic [NC-1:0]    b_crv, b_crr, b_cwv, b_cwr;
  logic [AB-1:0]    b_cra [NC];
  logic [AB-1:0]    b_cwa [NC];
  logic [DB-1:0]    b_crd [NC];
  logic [DB-1:0]    b_cwd [NC];
  logic [NCH_B-1:0] b_mrv, b_mwv;
  logic [NCH_B-1:0] b_mrr = '0;
  logic [NCH_B-1:0] b_mwr = '0;
  logic [AB-1:0]    b_mra [NCH_B];
  logic [AB-1:0]    b_mwa [NCH_B];
  logic [DB-1:0]    b_mrd [NCH_B] = '{default: '0};
  logic [DB-1:0]    b_mwd [NCH_B];

  dcache_mem_controller #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC),
                          .NUM_CHANNELS(NCH_A), .WRITE_ENABLE(1)) u_dut_a (
    .clk(clk), .reset(reset),
    .consumer_read_valid(a_crv), .consumer_read_address(a_cra),
    .consumer_read_ready(a_crr), .consumer_read_data(a_crd),
    .consumer_write_valid(a_cwv), .consumer_write_address(a_cwa),
    .consumer_write_data(a_cwd), .consumer_write_ready(a_cwr),
    .mem_read_valid(a_mrv), .mem_read_address(a_mra),
    .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
    .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
    .mem_write_data(a_mwd), .mem_write_ready(a_mwr)
  );

  dcache_mem_controller #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC),
                          .NUM_CHANNELS(NCH_B), .WRITE_ENABLE(0)) u_dut_b (
    .clk(clk), .reset(reset),
    .consumer_read_valid(b_crv), .consumer_read_address(b_cra),
    .consumer_read_ready(b_crr), .consumer_read_data(b_crd),
    .consumer_write_valid(b_cwv), .consumer_write_address(b_cwa),
    .consumer_write_data(b_cwd), .consumer_write_ready(b_cwr),
    .mem_read_valid(b_mrv), .mem_read_address(b_mra),
    .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
    .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
    .mem_write_data(b_mwd), .mem_write_ready(b_mwr)
  );

  // Memory model for A: accepts a request, waits 0..3 cycles (or forever while held),
  // pulses ready for one cycle; writes land in a_mem.
  bit             a_hold = 1'b0;
  bit             a_rand = 1'b0;
  bit             a_busy [NCH_A];
  int             a_cnt  [NCH_A];
  int             a_issues = 0;
  logic [DB-1:0]  a_mem [256];

  always @(posedge clk) begin
    #1;
    for (int c = 0; c < NCH_A; c++) begin
      if (a_mrr[c] || a_mwr[c]) begin
        a_mrr[c] = 1'b0; a_mwr[c] = 1'b0; a_busy[c] = 1'b0;
      end else if (!a_mrv[c] && !a_mwv[c]) begin
        a_busy[c] = 1'b0;
      end else begin
        if (!a_busy[c]) begin
          a_busy[c] = 1'b1;
          a_cnt[c]  = a_rand ? int'($urandom_range(0, 3)) : 0;
          a_issues++;
        end else if (a_cnt[c] > 0) begin
          a_cnt[c]--;
        end
        if (!a_hold && a_cnt[c] == 0) begin
          if (a_mrv[c]) begin
            a_mrr[c] = 1'b1; a_mrd[c] = a_mra[c] ^ 8'h54;
          end else begin
            a_mwr[c] = 1'b1; a_mem[a_mwa[c]] = a_mwd[c];
          end
        end
      end
    end
  end

  // Memory model for B: answers reads one cycle after seeing them while b_go is set.
  bit b_go = 1'b0;
  int b_fires = 0;
  always @(posedge clk) begin
    #1;
    for (int c = 0; c < NCH_B; c++) begin
      if (b_mrr[c]) b_mrr[c] = 1'b0;
      else if (b_mrv[c] && b_go) begin
        b_mrr[c] = 1'b1; b_mrd[c] = b_mra[c] ^ 8'h54; b_fires++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] acc;
    reset = 1'b1;
    a_crv = '0; a_cwv = '0; b_crv = '0; b_cwv = '0;
    for (int s = 0; s < NC; s++) begin
      a_cra[s] = '0; a_cwa[s] = '0; a_cwd[s] = '0;
      b_cra[s] = '0; b_cwa[s] = '0; b_cwd[s] = '0;
    end
    repeat (3) tick();
    acc = '0;
    for (int s = 0; s < NC; s++) acc = acc | a_crd[s] | b_crd[s];
    for (int c = 0; c < NCH_A; c++) acc = acc | a_mra[c] | a_mwa[c] | a_mwd[c];
    checks++;
    if ({a_crr, a_cwr, a_mrv, a_mwv} !== '0) begin
      failures++; $display("FAIL reset_ctrl_a: got %b want 0", {a_crr, a_cwr, a_mrv, a_mwv});
    end
    checks++;
    if ({b_crr, b_cwr, b_mrv, b_mwv} !== '0) begin
      failures++; $display("FAIL reset_ctrl_b: got %b want 0", {b_crr, b_cwr, b_mrv, b_mwv});
    end
    checks++;
    if (acc !== '0) begin failures++; $display("FAIL reset_data: OR of data/addr outputs %h want 0", acc); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    a_hold = 1'b0; a_rand = 1'b0;
    a_cra[0] = 8'hFF; a_crv[0] = 1'b1;
    tick();
    checks++;
    if (a_mrv !== 3'b001 || a_mra[0] !== 8'hFF || a_crr !== '0) begin
      failures++; $display("FAIL single_issue: mrv=%b addr=%h crr=%b want 001/ff/0", a_mrv, a_mra[0], a_crr);
    end
    tick();
    checks++;
    if (a_mrv !== '0 || a_crr !== 8'h01 || a_crd[0] !== 8'hAB) begin
      failures++; $display("FAIL single_return: mrv=%b crr=%h data=%h want 0/01/ab", a_mrv, a_crr, a_crd[0]);
    end
    repeat (3) tick();
    checks++;
    if (a_crr !== 8'h01 || a_crd[0] !== 8'hAB) begin
      failures++; $display("FAIL single_hold: crr=%h data=%h want 01/ab", a_crr, a_crd[0]);
    end
    a_crv[0] = 1'b0;
    tick();
    checks++;
    if (a_crr !== '0 || a_crd[0] !== '0) begin
      failures++; $display("FAIL single_release: crr=%h data=%h want 0/0", a_crr, a_crd[0]);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    a_cra[0] = 8'hFF; a_crv[0] = 1'b1;
    a_cwa[1] = 8'hF0; a_cwd[1] = 8'h5A; a_cwv[1] = 1'b1;
    tick();
    checks++;
    if (a_mrv !== 3'b001 || a_mra[0] !== 8'hFF || a_mwv !== 3'b010 || a_mwa[1] !== 8'hF0 || a_mwd[1] !== 8'h5A) begin
      failures++;
      $display("FAIL simul_issue: mrv=%b ra=%h mwv=%b wa=%h wd=%h want 001/ff/010/f0/5a", a_mrv, a_mra[0], a_mwv, a_mwa[1], a_mwd[1]);
    end
    tick();
    checks++;
    if (a_crr !== 8'h01 || a_crd[0] !== 8'hAB || a_cwr !== 8'h02 || a_mem[8'hF0] !== 8'h5A) begin
      failures++;
      $display("FAIL simul_return: crr=%h rd=%h cwr=%h mem=%h want 01/ab/02/5a", a_crr, a_crd[0], a_cwr, a_mem[8'hF0]);
    end
    a_crv[0] = 1'b0;
    tick();
    checks++;
    if (a_crr !== '0 || a_cwr !== 8'h02) begin
      failures++; $display("FAIL simul_independent: crr=%h cwr=%h want 00/02", a_crr, a_cwr);
    end
    a_cwv[1] = 1'b0;
    tick();
    checks++;
    if (a_cwr !== '0) begin failures++; $display("FAIL simul_wrelease: cwr=%h want 00", a_cwr); end
    tick();
  endtask

  task automatic test_read_before_write();
    a_cra[2] = 8'h40; a_crv[2] = 1'b1;
    a_cwa[2] = 8'h40; a_cwd[2] = 8'h77; a_cwv[2] = 1'b1;
    tick();
    checks++;
    if (a_mrv !== 3'b001 || a_mra[0] !== 8'h40 || a_mwv !== '0) begin
      failures++; $display("FAIL rw_read_first: mrv=%b ra=%h mwv=%b want 001/40/000", a_mrv, a_mra[0], a_mwv);
    end
    tick();
    checks++;
    if (a_crr !== 8'h04 || a_crd[2] !== (8'h40 ^ 8'h54) || a_cwr !== '0 || a_mwv !== '0) begin
      failures++; $display("FAIL rw_read_done: crr=%h rd=%h cwr=%h mwv=%b want 04/14/00/000", a_crr, a_crd[2], a_cwr, a_mwv);
    end
    a_crv[2] = 1'b0;
    tick();
    checks++;
    if (a_crr !== '0 || a_mwv !== '0) begin
      failures++; $display("FAIL rw_gap: crr=%h mwv=%b want 00/000", a_crr, a_mwv);
    end
    tick();
    checks++;
    if (a_mwv !== 3'b001 || a_mwa[0] !== 8'h40 || a_mwd[0] !== 8'h77) begin
      failures++; $display("FAIL rw_write_issue: mwv=%b wa=%h wd=%h want 001/40/77", a_mwv, a_mwa[0], a_mwd[0]);
    end
    tick();
    checks++;
    if (a_cwr !== 8'h04 || a_mem[8'h40] !== 8'h77) begin
      failures++; $display("FAIL rw_write_done: cwr=%h mem=%h want 04/77", a_cwr, a_mem[8'h40]);
    end
    a_cwv[2] = 1'b0;
    tick();
    checks++;
    if (a_cwr !== '0) begin failures++; $display("FAIL rw_release: cwr=%h want 00", a_cwr); end
    tick();
  endtask

  task automatic test_reset_mid();
    a_hold = 1'b1;
    a_cra[3] = 8'h33; a_crv[3] = 1'b1;
    tick();
    checks++;
    if (a_mrv !== 3'b001 || a_mra[0] !== 8'h33) begin
      failures++; $display("FAIL rmid_issue: mrv=%b ra=%h want 001/33", a_mrv, a_mra[0]);
    end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({a_crr, a_cwr, a_mrv, a_mwv} !== '0 || a_mra[0] !== '0) begin
      failures++; $display("FAIL rmid_abort: ctrl=%b ra=%h want 0/00", {a_crr, a_cwr, a_mrv, a_mwv}, a_mra[0]);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (a_mrv !== 3'b001 || a_mra[0] !== 8'h33) begin
      failures++; $display("FAIL rmid_reissue: mrv=%b ra=%h want 001/33", a_mrv, a_mra[0]);
    end
    a_hold = 1'b0;
    repeat (2) tick();
    checks++;
    if (a_crr !== 8'h08 || a_crd[3] !== (8'h33 ^ 8'h54)) begin
      failures++; $display("FAIL rmid_complete: crr=%h rd=%h want 08/67", a_crr, a_crd[3]);
    end
    a_crv[3] = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_random();
    int st [NC];
    int wt [NC];
    int idle [NC];
    int done [NC];
    bit is_wr [NC];
    logic [7:0] ad [NC];
    logic [7:0] dt [NC];
    int reqs = 0;
    bit all_done = 1'b0;
    a_rand = 1'b1; a_hold = 1'b0; a_issues = 0;
    for (int s = 0; s < NC; s++) begin
      st[s] = 0; wt[s] = 0; done[s] = 0; idle[s] = int'($urandom_range(0, 2));
    end
    for (int cyc = 0; cyc < 4000 && !all_done; cyc++) begin
      tick();
      for (int s = 0; s < NC; s++) begin
        case (st[s])
          0: if (done[s] < TXN) begin
            if (idle[s] > 0) idle[s]--;
            else begin
              is_wr[s] = $urandom_range(0, 1) == 1;
              ad[s] = {3'(s), 5'($urandom)};
              dt[s] = 8'($urandom);
              if (is_wr[s]) begin a_cwa[s] = ad[s]; a_cwd[s] = dt[s]; a_cwv[s] = 1'b1; end
              else begin a_cra[s] = ad[s]; a_crv[s] = 1'b1; end
              reqs++; wt[s] = 0; st[s] = 1;
            end
          end
          1: begin
            if (is_wr[s] ? a_cwr[s] : a_crr[s]) begin
              checks++;
              if (is_wr[s]) begin
                if (a_mem[ad[s]] !== dt[s]) begin
                  failures++; $display("FAIL rand_write slot %0d: mem[%h]=%h want %h", s, ad[s], a_mem[ad[s]], dt[s]);
                end
                a_cwv[s] = 1'b0;
              end else begin
                if (a_crd[s] !== (ad[s] ^ 8'h54)) begin
                  failures++; $display("FAIL rand_read slot %0d: data=%h want %h", s, a_crd[s], ad[s] ^ 8'h54);
                end
                a_crv[s] = 1'b0;
              end
              st[s] = 2; done[s]++;
            end else if (is_wr[s] ? a_crr[s] : a_cwr[s]) begin
              checks++; failures++;
              $display("FAIL rand_wrong_ready slot %0d: crr=%b cwr=%b want only %s", s, a_crr[s], a_cwr[s], is_wr[s] ? "write" : "read");
            end else if (++wt[s] > 200) begin
              checks++; failures++;
              $display("FAIL rand_timeout slot %0d: no ready after %0d cycles want completion", s, wt[s]);
              a_crv[s] = 1'b0; a_cwv[s] = 1'b0; st[s] = 2; done[s] = TXN;
            end
          end
          default: begin
            checks++;
            if (a_crr[s] !== 1'b0 || a_cwr[s] !== 1'b0) begin
              failures++; $display("FAIL rand_release slot %0d: crr=%b cwr=%b want 0/0", s, a_crr[s], a_cwr[s]);
            end
            st[s] = 0; idle[s] = int'($urandom_range(0, 3));
          end
        endcase
      end
      all_done = 1'b1;
      for (int s = 0; s < NC; s++) if (done[s] < TXN || st[s] != 0) all_done = 1'b0;
    end
    checks++;
    if (!all_done) begin failures++; $display("FAIL rand_budget: traffic not drained within cycle budget want drained"); end
    repeat (3) tick();
    checks++;
    if (a_issues != reqs || a_mrv !== '0 || a_mwv !== '0) begin
      failures++; $display("FAIL rand_issue_count: mem issues=%0d mrv=%b mwv=%b want %0d/0/0", a_issues, a_mrv, a_mwv, reqs);
    end
    a_rand = 1'b0;
  endtask

  task automatic test_two_channels();
    b_go = 1'b0; b_fires = 0;
    for (int s = 0; s < 4; s++) begin b_cra[s] = 8'h10 + 8'(s); b_crv[s] = 1'b1; end
    tick();
    checks++;
    if (b_mrv !== 2'b11 || b_mra[0] !== 8'h10 || b_mra[1] !== 8'h11) begin
      failures++; $display("FAIL two_first: mrv=%b a0=%h a1=%h want 11/10/11", b_mrv, b_mra[0], b_mra[1]);
    end
    tick();
    checks++;
    if (b_mrv !== 2'b11 || b_mra[0] !== 8'h10 || b_mra[1] !== 8'h11 || b_crr !== '0) begin
      failures++; $display("FAIL two_hold: mrv=%b a0=%h a1=%h crr=%h want 11/10/11/00", b_mrv, b_mra[0], b_mra[1], b_crr);
    end
    b_go = 1'b1;
    repeat (2) tick();
    checks++;
    if (b_crr !== 8'h03 || b_crd[0] !== (8'h10 ^ 8'h54) || b_crd[1] !== (8'h11 ^ 8'h54) || b_mrv !== '0) begin
      failures++; $display("FAIL two_done01: crr=%h d0=%h d1=%h mrv=%b want 03/44/45/00", b_crr, b_crd[0], b_crd[1], b_mrv);
    end
    b_crv[0] = 1'b0; b_crv[1] = 1'b0;
    tick();
    checks++;
    if (b_crr !== '0 || b_mrv !== '0) begin
      failures++; $display("FAIL two_gap: crr=%h mrv=%b want 00/00", b_crr, b_mrv);
    end
    tick();
    checks++;
    if (b_mrv !== 2'b11 || b_mra[0] !== 8'h12 || b_mra[1] !== 8'h13) begin
      failures++; $display("FAIL two_second: mrv=%b a0=%h a1=%h want 11/12/13", b_mrv, b_mra[0], b_mra[1]);
    end
    tick();
    checks++;
    if (b_crr !== 8'h0C || b_crd[2] !== (8'h12 ^ 8'h54) || b_crd[3] !== (8'h13 ^ 8'h54)) begin
      failures++; $display("FAIL two_done23: crr=%h d2=%h d3=%h want 0c/46/47", b_crr, b_crd[2], b_crd[3]);
    end
    b_crv[2] = 1'b0; b_crv[3] = 1'b0;
    repeat (2) tick();
    checks++;
    if (b_fires != 4 || b_crr !== '0) begin
      failures++; $display("FAIL two_count: mem reads=%0d crr=%h want 4/00", b_fires, b_crr);
    end
  endtask

  task automatic test_write_disabled();
    b_go = 1'b1;
    b_cwa[0] = 8'h05; b_cwd[0] = 8'h09; b_cwv[0] = 1'b1;
    repeat (4) begin
      tick();
      checks++;
      if (b_mwv !== '0 || b_mrv !== '0 || b_cwr !== '0) begin
        failures++; $display("FAIL nowrite_idle: mwv=%b mrv=%b cwr=%h want 0/0/0", b_mwv, b_mrv, b_cwr);
      end
    end
    b_cra[1] = 8'h21; b_crv[1] = 1'b1;
    tick();
    checks++;
    if (b_mrv !== 2'b01 || b_mra[0] !== 8'h21 || b_mwv !== '0) begin
      failures++; $display("FAIL nowrite_read_issue: mrv=%b ra=%h mwv=%b want 01/21/00", b_mrv, b_mra[0], b_mwv);
    end
    tick();
    checks++;
    if (b_crr !== 8'h02 || b_crd[1] !== (8'h21 ^ 8'h54) || b_mwa[0] !== '0 || b_mwd[0] !== '0) begin
      failures++; $display("FAIL nowrite_read_done: crr=%h rd=%h wa=%h wd=%h want 02/75/00/00", b_crr, b_crd[1], b_mwa[0], b_mwd[0]);
    end
    b_crv[1] = 1'b0; b_cwv[0] = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_read_before_write();
    test_reset_mid();
    test_random();
    test_two_channels();
    test_write_disabled();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dcache_mem_controller.md
# dcache_mem_controller

Arbitration stage directly downstream of the data cache: accepts per-consumer miss reads and write-throughs from the dcache controller-side ports and multiplexes them onto a smaller or equal number of external memory channels. Each channel runs an independent FSM that claims one pending request, forwards it to memory, and relays the memory acknowledge (and read data) back to the owning consumer slot. All handshakes are four-phase valid/ready, matching the dcache controller-side protocol.

## Interface
- ADDR_BITS, 8, address width
- DATA_BITS, 8, data width
- NUM_CONSUMERS, 8, request slots from dcache (one per dcache consumer)
- NUM_CHANNELS, 8, memory channels; 1 ≤ NUM_CHANNELS ≤ NUM_CONSUMERS
- WRITE_ENABLE, 1, 0 removes write path (write outputs tied 0, write requests never claimed)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- consumer_read_valid  in  [NUM_CONSUMERS]  dcache read request per slot
- consumer_read_address  in  ADDR_BITS x NUM_CONSUMERS (unpacked)  read address
- consumer_read_ready  out  [NUM_CONSUMERS]  read complete, data valid
- consumer_read_data  out  DATA_BITS x NUM_CONSUMERS  returned data
- consumer_write_valid  in  [NUM_CONSUMERS]  write request
- consumer_write_address  in  ADDR_BITS x NUM_CONSUMERS  write address
- consumer_write_data  in  DATA_BITS x NUM_CONSUMERS  write data
- consumer_write_ready  out  [NUM_CONSUMERS]  write complete
- mem_read_valid  out  [NUM_CHANNELS]  read request to memory
- mem_read_address  out  ADDR_BITS x NUM_CHANNELS
- mem_read_ready  in  [NUM_CHANNELS]  memory read done
- mem_read_data  in  DATA_BITS x NUM_CHANNELS
- mem_write_valid  out  [NUM_CHANNELS]
- mem_write_address  out  ADDR_BITS x NUM_CHANNELS
- mem_write_data  out  DATA_BITS x NUM_CHANNELS
- mem_write_ready  in  [NUM_CHANNELS]

## Operation
- Per-channel state: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING; per-channel owner index; per-slot claimed bit.
- IDLE: scan slots 0→NUM_CONSUMERS-1; first slot with (read_valid or write_valid) and not claimed is taken. Read beats write within a slot. Channels scan in index order within one cycle; a slot claimed by a lower channel in the same cycle is invisible to higher channels (never double-claimed).
- Claim read: latch address, set mem_read_valid, claimed=1 → READ_WAITING. Claim write: latch address/data, set mem_write_valid → WRITE_WAITING.
- READ_WAITING: on mem_read_ready, drop mem_read_valid, drive consumer_read_data[owner]=mem_read_data, consumer_read_ready[owner]=1 → READ_RELAYING. WRITE_WAITING analogous with consumer_write_ready.
- RELAYING: hold ready and data until owner drops its valid; then clear ready, clear claimed bit → IDLE. Read data held stable throughout; cleared to 0 when ready drops.
- Memory-side request held stable while WAITING regardless of consumer valid; a consumer dropping valid mid-request is a protocol violation (undefined).
- Slot with both read and write pending: read served first; write is claimed only after the read's claim clears.
- Addresses and data pass through unchanged; no width conversion.

## Timing
- Reset: all outputs 0, all channels IDLE, all claimed bits 0, owners 0; reset asserted mid-transaction aborts it at that edge with no completion signalled.
- Request valid sampled at edge N → mem_*_valid high after edge N (1-cycle latency).
- mem_*_ready sampled at edge M → mem_*_valid low and consumer_*_ready high after edge M.
- Consumer valid seen low at edge K → consumer ready low after edge K; channel may claim a new request at edge K+1 earliest.
- Minimum round trip with single-cycle memory: consumer valid to consumer ready = 2 edges.
- More pending slots than channels: excess slots wait; served lowest-index-first as channels free.

## Test plan
- Reset then slot 0 read 0xFF: mem_read_valid[0]=1 addr 0xFF one cycle later; mem_read_ready[0]=1 data 0xAB → next cycle mem_read_valid[0]=0, consumer_read_ready[0]=1, data 0xAB; held until read_valid[0] drops, then 0.
- Simultaneous slot 0 read 0xFF and slot 1 write 0xF0 data 0x5A: channel 0 takes read, channel 1 takes write same cycle; mem_write_data[1]=0x5A; both ready back independently.
- NUM_CHANNELS=2, slots 0-3 reading 0x10-0x13: channels serve slots 0,1 first; slots 2,3 claimed only after slots 0,1 complete; no duplicate mem requests.
- Slot 2 read 0x40 and write 0x40/0x77 both valid: read completes first; write issued only after read handshake finishes.
- Reset asserted while channel in READ_WAITING: all outputs 0 next cycle; after release, held request reissued.
- WRITE_ENABLE=0: write request on slot 0 never forwarded; mem_write_valid stays 0.
